// File: rtl/frontend_flush_ctrl_pkg.sv
// frontend_flush_ctrl_pkg: shared state encoding and the control bundle that drives the pipe register and PC unit.
package frontend_flush_ctrl_pkg;
  localparam int CNT_W = 4;
  typedef enum logic {RUN, RECOVER} ctrl_state_t;
  typedef struct packed {
    logic pipe_flush;
    logic pipe_hold;
    logic iq_flush;
    logic pc_redirect;
    logic pc_stall;
  } fe_ctrl_t;
endpackage

// File: rtl/frontend_recover_cnt.sv
// frontend_recover_cnt: loadable down-counter; done flags the last counted cycle.
module frontend_recover_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else r_cnt <= load ? load_val : (dec && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  assign done = r_cnt == W'(1);
endmodule

// File: rtl/frontend_flush_ctrl.sv
// frontend_flush_ctrl: load/hold/flush and redirect sequencing for the fetch->issue pipe register and PC stage.
// Optional statistics counters are enabled by defining FRONTEND_FLUSH_STATS_EN.
module frontend_flush_ctrl
  import frontend_flush_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            queue_full,
  input  logic            issue_valid,
  input  logic            issue_branch,
  input  logic            issue_pred_taken,
  input  logic            issue_jump,
  input  logic [XLEN-1:0] issue_target,
  input  logic            commit_mispredict,
  input  logic [XLEN-1:0] commit_target,
`ifdef FRONTEND_FLUSH_STATS_EN
  output logic [31:0]     stat_issue_redirects,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic            pipe_flush,
  output logic            pipe_hold,
  output logic            iq_flush,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            pc_stall,
  output logic            busy
);
  ctrl_state_t     r_state, w_next;
  fe_ctrl_t        w_ctrl;
  logic            r_init;
  logic            w_act, w_issue_redir, w_load, w_dec, w_done, w_busy, w_issue_fire;
  logic [XLEN-1:0] w_pc;
  assign w_issue_redir = issue_valid & (issue_jump | (issue_branch & issue_pred_taken));
  // r_init masks everything during reset and the first cycle after release
  assign w_act = ~r_init;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= RUN;
      r_init  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_init  <= 1'b0;
    end
  always_comb begin
    w_ctrl       = '0;
    w_pc         = '0;
    w_busy       = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_issue_fire = 1'b0;
    w_next       = r_state;
    if (w_act && r_state == RUN) begin
      if (commit_mispredict) begin
        w_ctrl.pipe_flush  = 1'b1;
        w_ctrl.iq_flush    = 1'b1;
        w_ctrl.pc_redirect = 1'b1;
        w_pc               = commit_target;
        w_load             = 1'b1;
        w_next             = RECOVER;
      end else if (queue_full) begin
        w_ctrl.pipe_hold = 1'b1;
        w_ctrl.pc_stall  = 1'b1;
      end else if (w_issue_redir) begin
        w_ctrl.pipe_flush  = 1'b1;
        w_ctrl.pc_redirect = 1'b1;
        w_pc               = issue_target;
        w_issue_fire       = 1'b1;
      end
    end else if (w_act) begin
      // a fresh mispredict redirects, so the stall is released for that cycle
      w_busy             = 1'b1;
      w_dec              = 1'b1;
      w_ctrl.pipe_flush  = 1'b1;
      w_ctrl.pc_stall    = ~commit_mispredict;
      w_ctrl.iq_flush    = commit_mispredict;
      w_ctrl.pc_redirect = commit_mispredict;
      w_pc               = commit_mispredict ? commit_target : '0;
      w_load             = commit_mispredict;
      w_next             = (!commit_mispredict && w_done) ? RUN : RECOVER;
    end
  end
  frontend_recover_cnt #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .load_val(CNT_W'(RECOVER_CYCLES)),
    .dec     (w_dec),
    .done    (w_done)
  );
  assign pipe_flush  = w_ctrl.pipe_flush;
  assign pipe_hold   = w_ctrl.pipe_hold;
  assign iq_flush    = w_ctrl.iq_flush;
  assign pc_redirect = w_ctrl.pc_redirect;
  assign pc_stall    = w_ctrl.pc_stall;
  assign redirect_pc = w_pc;
  assign busy        = w_busy;
`ifdef FRONTEND_FLUSH_STATS_EN
  logic [31:0] r_stat_ir, r_stat_mp;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_stat_ir <= '0;
      r_stat_mp <= '0;
    end else begin
      r_stat_ir <= (w_issue_fire && r_stat_ir != '1) ? r_stat_ir + 1'b1 : r_stat_ir;
      r_stat_mp <= (w_load && r_stat_mp != '1) ? r_stat_mp + 1'b1 : r_stat_mp;
    end
  assign stat_issue_redirects = r_stat_ir;
  assign stat_mispredicts     = r_stat_mp;
`endif
endmodule

// File: tb/tb_frontend_flush_ctrl.sv
// tb_frontend_flush_ctrl: directed scoreboard bench for frontend_flush_ctrl (RECOVER_CYCLES=2).
module tb_frontend_flush_ctrl;
  logic        clk = 1'b0, reset = 1'b0;
  logic        queue_full = 1'b0, issue_valid = 1'b0, issue_branch = 1'b0;
  logic        issue_pred_taken = 1'b0, issue_jump = 1'b0, commit_mispredict = 1'b0;
  logic [31:0] issue_target = '0, commit_target = '0;
  logic        pipe_flush, pipe_hold, iq_flush, pc_redirect, pc_stall, busy;
  logic [31:0] redirect_pc;
  int          tests = 0, fails = 0;
`ifdef FRONTEND_FLUSH_STATS_EN
  logic [31:0] stat_issue_redirects, stat_mispredicts;
`endif
  typedef struct {
    string       tag;
    logic [37:0] v;
  } exp_t;
  exp_t sb[$];
  frontend_flush_ctrl #(.XLEN(32), .RECOVER_CYCLES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .queue_full       (queue_full),
    .issue_valid      (issue_valid),
    .issue_branch     (issue_branch),
    .issue_pred_taken (issue_pred_taken),
    .issue_jump       (issue_jump),
    .issue_target     (issue_target),
    .commit_mispredict(commit_mispredict),
    .commit_target    (commit_target),
`ifdef FRONTEND_FLUSH_STATS_EN
    .stat_issue_redirects(stat_issue_redirects),
    .stat_mispredicts    (stat_mispredicts),
`endif
    .pipe_flush       (pipe_flush),
    .pipe_hold        (pipe_hold),
    .iq_flush         (iq_flush),
    .pc_redirect      (pc_redirect),
    .redirect_pc      (redirect_pc),
    .pc_stall         (pc_stall),
    .busy             (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // flags order: {busy, pc_stall, pc_redirect, iq_flush, pipe_hold, pipe_flush}
  task automatic step(input string tag, input logic rst, qf, iv, ib, ipt, ij,
                      input logic [31:0] it, input logic mp, input logic [31:0] ct,
                      input logic [5:0] ef, input logic [31:0] epc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; queue_full = qf; issue_valid = iv; issue_branch = ib;
    issue_pred_taken = ipt; issue_jump = ij; issue_target = it;
    commit_mispredict = mp; commit_target = ct;
    e.tag = tag;
    e.v   = {ef, epc};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, {busy, pc_stall, pc_redirect, iq_flush, pipe_hold, pipe_flush, redirect_pc}, e.v);
    chk({e.tag, "_inv"}, {36'd0, pipe_flush & pipe_hold, pc_redirect & pc_stall}, 38'd0);
    chk({e.tag, "_pc0"}, {6'd0, pc_redirect ? 32'd0 : redirect_pc}, 38'd0);
  endtask
  initial begin
    #3 reset = 1'b1;
    step("rst_hold",   1, 0, 1, 0, 0, 1, 32'h100, 1, 32'h2000, 6'b000000, 32'h0);
    step("rst_rel",    0, 0, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b000000, 32'h0);
    step("jump",       0, 0, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b001001, 32'h100);
    step("qf_1",       0, 1, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b010010, 32'h0);
    step("qf_2",       0, 1, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b010010, 32'h0);
    step("qf_drop",    0, 0, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b001001, 32'h100);
    step("mp_run",     0, 0, 1, 1, 1, 0, 32'h100, 1, 32'h2000, 6'b001101, 32'h2000);
    step("rec_1",      0, 1, 1, 1, 1, 0, 32'h100, 0, 32'h0,    6'b110001, 32'h0);
    step("rec_2",      0, 0, 1, 1, 1, 0, 32'h100, 0, 32'h0,    6'b110001, 32'h0);
    step("back_run",   0, 0, 1, 1, 1, 0, 32'h100, 0, 32'h0,    6'b001001, 32'h100);
    step("nottaken",   0, 0, 1, 1, 0, 0, 32'h140, 0, 32'h0,    6'b000000, 32'h0);
    step("mp2_run",    0, 0, 0, 0, 0, 0, 32'h0,   1, 32'h2000, 6'b001101, 32'h2000);
    step("mp2_rec",    0, 0, 1, 0, 0, 1, 32'h100, 1, 32'h3000, 6'b101101, 32'h3000);
    step("rel_1",      0, 0, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b110001, 32'h0);
    step("rel_2",      0, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0,    6'b110001, 32'h0);
    step("rel_run",    0, 1, 0, 0, 0, 0, 32'h0,   0, 32'h0,    6'b010010, 32'h0);
`ifdef FRONTEND_FLUSH_STATS_EN
    chk("stat_ir", {6'd0, stat_issue_redirects}, {6'd0, 32'd3});
    chk("stat_mp", {6'd0, stat_mispredicts}, {6'd0, 32'd3});
`endif
    step("mp3_run",    0, 0, 0, 0, 0, 0, 32'h0,   1, 32'h4000, 6'b001101, 32'h4000);
    step("rst_rec_1",  1, 0, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b000000, 32'h0);
    step("rst_rec_2",  1, 0, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b000000, 32'h0);
    step("rst_rec_3",  1, 0, 1, 0, 0, 1, 32'h100, 1, 32'h5000, 6'b000000, 32'h0);
`ifdef FRONTEND_FLUSH_STATS_EN
    chk("stat_ir_rst", {6'd0, stat_issue_redirects}, 38'd0);
    chk("stat_mp_rst", {6'd0, stat_mispredicts}, 38'd0);
`endif
    step("rst_rel2",   0, 0, 1, 0, 0, 1, 32'h100, 0, 32'h0,    6'b000000, 32'h0);
    step("run_after",  0, 0, 1, 0, 0, 1, 32'h180, 0, 32'h0,    6'b001001, 32'h180);
    step("idle",       0, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0,    6'b000000, 32'h0);
`ifdef FRONTEND_FLUSH_STATS_EN
    chk("stat_ir_end", {6'd0, stat_issue_redirects}, {6'd0, 32'd1});
    chk("stat_mp_end", {6'd0, stat_mispredicts}, 38'd0);
`endif
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
